// File: rtl/regfile_sb.sv
// Two-read/one-write register file with a hard-zero index, optional write-to-read
// bypass and a per-register pending-write scoreboard for the hazard unit.
module regfile_sb #(
    parameter int WIDTH    = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1,
    localparam int DEPTH   = 2 ** ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] ra_i,
    input  logic [ADDR_W-1:0] rb_i,
    output logic [WIDTH-1:0]  busA_o,
    output logic [WIDTH-1:0]  busB_o,
    output logic              busyA_o,
    output logic              busyB_o,
    input  logic              regWr_i,
    input  logic [ADDR_W-1:0] rw_i,
    input  logic [WIDTH-1:0]  busW_i,
    input  logic              issue_i,
    input  logic [ADDR_W-1:0] issueRd_i,
    output logic [DEPTH-1:0]  pending_o
);

    localparam logic [ADDR_W-1:0] ZERO_IDX  = ADDR_W'(ZERO_REG);
    localparam bit                BYPASS_EN = (BYPASS != 0);

    logic [WIDTH-1:0] regFile_q [DEPTH];
    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;
    logic             writeEn;
    logic             issueSet;
    logic             bypassA;
    logic             bypassB;

    assign writeEn  = regWr_i && (rw_i != ZERO_IDX);
    assign issueSet = issue_i && (issueRd_i != ZERO_IDX);

    // The zero register is never written, so writeEn already excludes it from bypass.
    assign bypassA = BYPASS_EN && writeEn && (rw_i == ra_i);
    assign bypassB = BYPASS_EN && writeEn && (rw_i == rb_i);

    always_ff @(negedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                regFile_q[i] <= '0;
            end
        end else if (writeEn) begin
            regFile_q[rw_i] <= busW_i;
        end
    end

    // Set is applied after clear so a new producer wins over the retiring one.
    always_comb begin
        pending_d = pending_q;
        if (writeEn) begin
            pending_d[rw_i] = 1'b0;
        end
        if (issueSet) begin
            pending_d[issueRd_i] = 1'b1;
        end
    end

    always_ff @(negedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_comb begin
        busA_o = '0;
        if (!rst_i && (ra_i != ZERO_IDX)) begin
            busA_o = bypassA ? busW_i : regFile_q[ra_i];
        end
    end

    always_comb begin
        busB_o = '0;
        if (!rst_i && (rb_i != ZERO_IDX)) begin
            busB_o = bypassB ? busW_i : regFile_q[rb_i];
        end
    end

    // A register being retired through the bypass is no longer a hazard this cycle.
    always_comb begin
        busyA_o = 1'b0;
        busyB_o = 1'b0;
        if (!rst_i) begin
            busyA_o = (ra_i != ZERO_IDX) && pending_q[ra_i] && !bypassA;
            busyB_o = (rb_i != ZERO_IDX) && pending_q[rb_i] && !bypassB;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default (bypass), no-bypass and a 16x32 zero-at-r0 build.
module tb_regfile_sb;

    logic        clk;
    logic        rst;

    logic [4:0]  ra, rb, rw, issueRd;
    logic [63:0] busW;
    logic        regWr, issue;
    logic [63:0] busA1, busB1, busA0, busB0;
    logic        busyA1, busyB1, busyA0, busyB0;
    logic [31:0] pend1, pend0;

    logic [3:0]  ra2, rb2, rw2, issueRd2;
    logic [31:0] busW2, busA2, busB2;
    logic        regWr2, issue2, busyA2, busyB2;
    logic [15:0] pend2;

    int checks = 0;
    int errors = 0;

    regfile_sb #(.WIDTH(64), .ADDR_W(5), .ZERO_REG(31), .BYPASS(1)) dutByp (
        .clk_i(clk), .rst_i(rst), .ra_i(ra), .rb_i(rb),
        .busA_o(busA1), .busB_o(busB1), .busyA_o(busyA1), .busyB_o(busyB1),
        .regWr_i(regWr), .rw_i(rw), .busW_i(busW),
        .issue_i(issue), .issueRd_i(issueRd), .pending_o(pend1)
    );

    regfile_sb #(.WIDTH(64), .ADDR_W(5), .ZERO_REG(31), .BYPASS(0)) dutNoByp (
        .clk_i(clk), .rst_i(rst), .ra_i(ra), .rb_i(rb),
        .busA_o(busA0), .busB_o(busB0), .busyA_o(busyA0), .busyB_o(busyB0),
        .regWr_i(regWr), .rw_i(rw), .busW_i(busW),
        .issue_i(issue), .issueRd_i(issueRd), .pending_o(pend0)
    );

    regfile_sb #(.WIDTH(32), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) dutSmall (
        .clk_i(clk), .rst_i(rst), .ra_i(ra2), .rb_i(rb2),
        .busA_o(busA2), .busB_o(busB2), .busyA_o(busyA2), .busyB_o(busyB2),
        .regWr_i(regWr2), .rw_i(rw2), .busW_i(busW2),
        .issue_i(issue2), .issueRd_i(issueRd2), .pending_o(pend2)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next active (falling) edge into the settled low phase.
    task automatic applyStimulus();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ra = '0; rb = '0; rw = '0; issueRd = '0; busW = '0; regWr = 1'b0; issue = 1'b0;
        ra2 = '0; rb2 = '0; rw2 = '0; issueRd2 = '0; busW2 = '0; regWr2 = 1'b0; issue2 = 1'b0;
        #2;
        checkOutput("reset pending", 64'(pend1), 64'h0);
        checkOutput("reset busA", busA1, 64'h0);
        checkOutput("reset busyA", 64'(busyA1), 64'h0);
        checkOutput("reset small pending", 64'(pend2), 64'h0);
        applyStimulus();
        rst = 1'b0;

        // Mid-run reset
        regWr = 1'b1; rw = 5'd3; busW = 64'hDEAD;
        applyStimulus();
        regWr = 1'b0; issue = 1'b1; issueRd = 5'd3;
        applyStimulus();
        issue = 1'b0; ra = 5'd3;
        #1;
        checkOutput("r3 written", busA1, 64'hDEAD);
        checkOutput("r3 pending", 64'(pend1), 64'h8);
        #1 rst = 1'b1;
        #1;
        checkOutput("async reset busA", busA1, 64'h0);
        checkOutput("async reset pending", 64'(pend1), 64'h0);
        checkOutput("async reset nobyp busA", busA0, 64'h0);
        regWr = 1'b1; rw = 5'd6; busW = 64'h55; ra = 5'd6;
        #1;
        checkOutput("reset gates bypass", busA1, 64'h0);
        applyStimulus();
        rst = 1'b0; regWr = 1'b0;
        #1;
        checkOutput("write under reset dropped", busA1, 64'h0);

        // Zero register
        ra = 5'd31; regWr = 1'b1; rw = 5'd31; busW = 64'hFFFF;
        #1;
        checkOutput("zero reg during write", busA1, 64'h0);
        applyStimulus();
        regWr = 1'b0;
        #1;
        checkOutput("zero reg after write", busA1, 64'h0);
        issue = 1'b1; issueRd = 5'd31;
        applyStimulus();
        issue = 1'b0;
        #1;
        checkOutput("zero reg never pending", 64'(pend1), 64'h0);
        checkOutput("zero reg not busy", 64'(busyA1), 64'h0);

        // Bypass vs no bypass; same-edge issue+retire keeps r5 pending
        regWr = 1'b1; rw = 5'd5; busW = 64'h1111; issue = 1'b1; issueRd = 5'd5;
        applyStimulus();
        regWr = 1'b0; issue = 1'b0; ra = 5'd5; rb = 5'd5;
        #1;
        checkOutput("r5 old value", busA0, 64'h1111);
        checkOutput("r5 pending same-edge", 64'(pend1), 64'h20);
        checkOutput("r5 busy", 64'(busyA1), 64'h1);
        regWr = 1'b1; busW = 64'h1234;
        #1;
        checkOutput("bypass busA", busA1, 64'h1234);
        checkOutput("bypass busB", busB1, 64'h1234);
        checkOutput("bypass busyA", 64'(busyA1), 64'h0);
        checkOutput("bypass busyB", 64'(busyB1), 64'h0);
        checkOutput("nobyp busA before edge", busA0, 64'h1111);
        checkOutput("nobyp busyA before edge", 64'(busyA0), 64'h1);
        applyStimulus();
        regWr = 1'b0;
        #1;
        checkOutput("nobyp busA after edge", busA0, 64'h1234);
        checkOutput("nobyp busB after edge", busB0, 64'h1234);
        checkOutput("r5 retired", 64'(pend0), 64'h0);

        // Scoreboard on r7
        ra = 5'd7; rb = 5'd0; issue = 1'b1; issueRd = 5'd7;
        applyStimulus();
        issue = 1'b0;
        #1;
        checkOutput("r7 busy byp", 64'(busyA1), 64'h1);
        checkOutput("r7 busy nobyp", 64'(busyA0), 64'h1);
        checkOutput("r0 not busy", 64'(busyB1), 64'h0);
        regWr = 1'b1; rw = 5'd7; busW = 64'h77;
        #1;
        checkOutput("r7 busy cleared by bypass", 64'(busyA1), 64'h0);
        checkOutput("r7 busy held nobyp", 64'(busyA0), 64'h1);
        applyStimulus();
        regWr = 1'b0;
        #1;
        checkOutput("r7 retired busy", 64'(busyA0), 64'h0);
        checkOutput("r7 retired pending", 64'(pend1), 64'h0);
        issue = 1'b1; issueRd = 5'd7; regWr = 1'b1; rw = 5'd7; busW = 64'h99;
        applyStimulus();
        issue = 1'b0; regWr = 1'b0;
        #1;
        checkOutput("r7 new producer wins", 64'(pend1), 64'h80);
        checkOutput("r7 data", busA0, 64'h99);

        // Independent set/clear on different registers
        issue = 1'b1; issueRd = 5'd9;
        applyStimulus();
        issue = 1'b0;
        #1;
        checkOutput("r9 pending", 64'(pend1), 64'h280);
        issue = 1'b1; issueRd = 5'd2; regWr = 1'b1; rw = 5'd9; busW = 64'h9;
        applyStimulus();
        issue = 1'b0; regWr = 1'b0;
        #1;
        checkOutput("set r2 clear r9", 64'(pend1), 64'h84);
        regWr = 1'b1; rw = 5'd12; busW = 64'h12;
        applyStimulus();
        regWr = 1'b0;
        #1;
        checkOutput("clear idle bit", 64'(pend1), 64'h84);

        // Small build sweep with zero register at index 0
        for (int i = 0; i < 16; i++) begin
            regWr2 = 1'b1; rw2 = 4'(i); busW2 = 32'(i * 3);
            applyStimulus();
        end
        regWr2 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ra2 = 4'(i); rb2 = 4'(15 - i);
            #1;
            checkOutput($sformatf("sweep A r%0d", i), 64'(busA2), (i == 0) ? 64'h0 : 64'(i * 3));
            checkOutput($sformatf("sweep B r%0d", 15 - i), 64'(busB2), (i == 15) ? 64'h0 : 64'((15 - i) * 3));
        end
        issue2 = 1'b1; issueRd2 = 4'd0;
        applyStimulus();
        issueRd2 = 4'd15;
        applyStimulus();
        issue2 = 1'b0; ra2 = 4'd15; rb2 = 4'd0;
        #1;
        checkOutput("small pending", 64'(pend2), 64'h8000);
        checkOutput("small busy r15", 64'(busyA2), 64'h1);
        checkOutput("small busy r0", 64'(busyB2), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
